// File: rtl/stream_packet_arbiter.sv
// Round-robin packet arbiter: NUM_SRC vector streams share one registered sink port.
// A grant is held from the first accepted beat until the beat carrying last is accepted.
module stream_packet_arbiter #(
    parameter int NUM_SRC     = 4,
    parameter int DATA_WIDTH  = 32,
    parameter int VECTOR_SIZE = 1,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                                      clkIn,
    input  logic                                      rstIn,
    input  logic [NUM_SRC*DATA_WIDTH*VECTOR_SIZE-1:0] dataIn,
    input  logic [NUM_SRC*VECTOR_SIZE-1:0]            validIn,
    input  logic [NUM_SRC-1:0]                        lastIn,
    output logic [NUM_SRC-1:0]                        readyOut,
    output logic [DATA_WIDTH*VECTOR_SIZE-1:0]         dataOut,
    output logic [VECTOR_SIZE-1:0]                    validOut,
    output logic                                      lastOut,
    input  logic                                      readyIn,
    output logic [NUM_SRC-1:0]                        grantOut,
    output logic [CNT_WIDTH-1:0]                      pktCountOut
);

    localparam int BeatW = DATA_WIDTH * VECTOR_SIZE;
    localparam int PtrW  = $clog2(NUM_SRC);

    typedef enum logic {
        Idle,
        Lock
    } state_t;

    state_t state;

    logic [PtrW-1:0]      rrPtr;
    logic [PtrW-1:0]      grantIdx;
    logic [NUM_SRC-1:0]   req;
    logic                 anyReq;
    logic [2*NUM_SRC-1:0] reqTwice;
    logic [NUM_SRC-1:0]   reqRot;
    logic                 found;
    logic [PtrW-1:0]      offset;
    logic [PtrW:0]        pickSum;
    logic [PtrW-1:0]      pickIdx;
    logic [NUM_SRC-1:0]   pick;

    logic [BeatW-1:0]       selData;
    logic [VECTOR_SIZE-1:0] selValid;
    logic                   selLast;
    logic                   selReq;

    logic outBusy;
    logic slotFree;
    logic accept;
    logic acceptLast;

    always_comb begin
        for (int s = 0; s < NUM_SRC; s++) begin
            req[s] = |validIn[s*VECTOR_SIZE +: VECTOR_SIZE];
        end
    end

    assign anyReq = |req;

    // Rotate requests so that bit 0 is the source at the round-robin pointer.
    always_comb begin
        reqTwice = {req, req} >> rrPtr;
        reqRot   = reqTwice[NUM_SRC-1:0];
        found    = 1'b0;
        offset   = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (!found && reqRot[i]) begin
                found  = 1'b1;
                offset = PtrW'(i);
            end
        end
        pickSum = {1'b0, rrPtr} + {1'b0, offset};
        if (pickSum >= (PtrW+1)'(NUM_SRC)) begin
            pickSum = pickSum - (PtrW+1)'(NUM_SRC);
        end
        pickIdx = pickSum[PtrW-1:0];
        pick    = NUM_SRC'(1) << pickIdx;
    end

    // One-hot grant drives an AND-OR mux of the granted source beat.
    always_comb begin
        selData  = '0;
        selValid = '0;
        selLast  = 1'b0;
        selReq   = 1'b0;
        for (int s = 0; s < NUM_SRC; s++) begin
            if (grantOut[s]) begin
                selData  = selData  | dataIn[s*BeatW +: BeatW];
                selValid = selValid | validIn[s*VECTOR_SIZE +: VECTOR_SIZE];
                selLast  = selLast  | lastIn[s];
                selReq   = selReq   | req[s];
            end
        end
    end

    assign outBusy    = |validOut;
    assign slotFree   = !outBusy || readyIn;
    assign readyOut   = (state == Lock && slotFree) ? grantOut : '0;
    assign accept     = (state == Lock) && slotFree && selReq;
    assign acceptLast = accept && selLast;

    always_ff @(posedge clkIn or negedge rstIn) begin
        if (!rstIn) begin
            state       <= Idle;
            rrPtr       <= '0;
            grantIdx    <= '0;
            grantOut    <= '0;
            pktCountOut <= '0;
        end else begin
            unique case (state)
                Idle: begin
                    if (anyReq) begin
                        grantOut <= pick;
                        grantIdx <= pickIdx;
                        state    <= Lock;
                    end
                end
                Lock: begin
                    if (acceptLast) begin
                        pktCountOut <= pktCountOut + 1'b1;
                        rrPtr       <= (grantIdx == PtrW'(NUM_SRC - 1)) ?
                                       '0 : grantIdx + 1'b1;
                        grantOut    <= '0;
                        state       <= Idle;
                    end
                end
                default: state <= Idle;
            endcase
        end
    end

    // Output register: refill on accept, otherwise drain when the sink takes it.
    always_ff @(posedge clkIn or negedge rstIn) begin
        if (!rstIn) begin
            dataOut  <= '0;
            validOut <= '0;
            lastOut  <= 1'b0;
        end else if (accept) begin
            dataOut  <= selData;
            validOut <= selValid;
            lastOut  <= selLast;
        end else if (outBusy && readyIn) begin
            validOut <= '0;
            lastOut  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_stream_packet_arbiter.sv
// Bench for stream_packet_arbiter: directed scenarios plus a randomized
// run against a packet-level round-robin reference model.
module tb_stream_packet_arbiter;

    localparam int NS = 4;
    localparam int DW = 8;
    localparam int VS = 4;
    localparam int CW = 4;
    localparam int BW = DW * VS;

    typedef struct packed {
        logic [BW-1:0] d;
        logic [VS-1:0] v;
        logic          l;
    } beat_t;

    logic clkIn = 1'b0;
    logic rstIn = 1'b0;

    logic [NS*BW-1:0] dataIn;
    logic [NS*VS-1:0] validIn;
    logic [NS-1:0]    lastIn;
    logic [NS-1:0]    readyOut;
    logic [BW-1:0]    dataOut;
    logic [VS-1:0]    validOut;
    logic             lastOut;
    logic             readyIn;
    logic [NS-1:0]    grantOut;
    logic [CW-1:0]    pktCountOut;

    logic [BW-1:0] srcData  [NS];
    logic [VS-1:0] srcValid [NS];
    logic          srcLast  [NS];
    logic          srcReady [NS];

    int nTests = 0;
    int nFail  = 0;

    beat_t      srcQ [NS][$];
    logic [NS-1:0] pause;
    logic       sinkRdy;

    always #5 clkIn = ~clkIn;

    for (genvar g = 0; g < NS; g++) begin : g_map
        assign dataIn[g*BW +: BW]  = srcData[g];
        assign validIn[g*VS +: VS] = srcValid[g];
        assign lastIn[g]           = srcLast[g];
        assign srcReady[g]         = readyOut[g];
    end

    stream_packet_arbiter #(
        .NUM_SRC(NS),
        .DATA_WIDTH(DW),
        .VECTOR_SIZE(VS),
        .CNT_WIDTH(CW)
    ) dut (
        .clkIn(clkIn),
        .rstIn(rstIn),
        .dataIn(dataIn),
        .validIn(validIn),
        .lastIn(lastIn),
        .readyOut(readyOut),
        .dataOut(dataOut),
        .validOut(validOut),
        .lastOut(lastOut),
        .readyIn(readyIn),
        .grantOut(grantOut),
        .pktCountOut(pktCountOut)
    );

    function automatic beat_t mk(logic [BW-1:0] d, logic [VS-1:0] v, logic l);
        beat_t b;
        b.d = d;
        b.v = v;
        b.l = l;
        return b;
    endfunction

    // Present queue heads at the falling edge; idle sources show junk data/last.
    task automatic drive();
        @(negedge clkIn);
        for (int s = 0; s < NS; s++) begin
            if (srcQ[s].size() > 0 && !pause[s]) begin
                srcData[s]  = srcQ[s][0].d;
                srcValid[s] = srcQ[s][0].v;
                srcLast[s]  = srcQ[s][0].l;
            end else begin
                srcData[s]  = $urandom;
                srcValid[s] = '0;
                srcLast[s]  = 1'($urandom);
            end
        end
        readyIn = sinkRdy;
        #1;
    endtask

    task automatic advance();
        logic [NS-1:0] acc;
        for (int s = 0; s < NS; s++) begin
            acc[s] = srcReady[s] && (srcValid[s] != '0);
        end
        @(posedge clkIn);
        for (int s = 0; s < NS; s++) begin
            if (acc[s] && srcQ[s].size() > 0) void'(srcQ[s].pop_front());
        end
    endtask

    task automatic applyReset();
        rstIn   = 1'b0;
        pause   = '0;
        sinkRdy = 1'b1;
        readyIn = 1'b1;
        for (int s = 0; s < NS; s++) begin
            srcQ[s].delete();
            srcData[s]  = '0;
            srcValid[s] = '0;
            srcLast[s]  = 1'b0;
        end
        repeat (2) @(negedge clkIn);
        rstIn = 1'b1;
    endtask

    task automatic test_reset();
        applyReset();
        srcQ[0].push_back(mk(32'h11, 4'hF, 1'b1));
        for (int b = 0; b < 4; b++) srcQ[1].push_back(mk(32'h21 + b, 4'hF, b == 3));
        repeat (5) begin
            drive();
            advance();
        end
        #3;
        rstIn = 1'b0;
        for (int s = 0; s < NS; s++) srcValid[s] = '0;
        #1;
        nTests++;
        if (grantOut !== '0) begin
            nFail++;
            $display("FAIL rst_grant got=%b want=0000", grantOut);
        end
        nTests++;
        if (readyOut !== '0) begin
            nFail++;
            $display("FAIL rst_ready got=%b want=0000", readyOut);
        end
        nTests++;
        if ({validOut, lastOut} !== '0) begin
            nFail++;
            $display("FAIL rst_valid got=%b/%b want=0/0", validOut, lastOut);
        end
        nTests++;
        if (dataOut !== '0) begin
            nFail++;
            $display("FAIL rst_data got=%h want=0", dataOut);
        end
        nTests++;
        if (pktCountOut !== '0) begin
            nFail++;
            $display("FAIL rst_count got=%0d want=0", pktCountOut);
        end
        for (int s = 0; s < NS; s++) srcQ[s].delete();
        srcQ[0].push_back(mk(32'h31, 4'hF, 1'b1));
        srcQ[3].push_back(mk(32'h34, 4'hF, 1'b1));
        @(negedge clkIn);
        rstIn = 1'b1;
        drive();
        nTests++;
        if (grantOut !== '0) begin
            nFail++;
            $display("FAIL rst_idle got=%b want=0000", grantOut);
        end
        advance();
        drive();
        nTests++;
        if (grantOut !== 4'b0001) begin
            nFail++;
            $display("FAIL rst_first_grant got=%b want=0001", grantOut);
        end
        advance();
    endtask

    task automatic test_round_robin();
        logic [NS-1:0] gLog [32];
        logic [VS-1:0] vLog [32];
        logic [BW-1:0] dLog [32];
        logic          lLog [32];
        logic [CW-1:0] cLog [32];
        int idx;
        applyReset();
        for (int p = 0; p < 2; p++)
            for (int s = 0; s < NS; s++)
                for (int b = 0; b < 3; b++)
                    srcQ[s].push_back(mk(BW'((s << 16) | (p << 8) | b), 4'hF, b == 2));
        for (int c = 0; c < 30; c++) begin
            drive();
            gLog[c] = grantOut;
            vLog[c] = validOut;
            dLog[c] = dataOut;
            lLog[c] = lastOut;
            cLog[c] = pktCountOut;
            advance();
        end
        nTests++;
        if (gLog[0] !== '0 || vLog[1] !== '0) begin
            nFail++;
            $display("FAIL rr_latency grant0=%b valid1=%b want 0000/0", gLog[0], vLog[1]);
        end
        idx = 2;
        for (int k = 0; k < 5; k++) begin
            nTests++;
            if (gLog[idx-1] !== NS'(1) << (k % NS)) begin
                nFail++;
                $display("FAIL rr_grant pkt%0d got=%b want=%b", k, gLog[idx-1],
                         NS'(1) << (k % NS));
            end
            for (int b = 0; b < 3; b++) begin
                nTests++;
                if ({vLog[idx], dLog[idx], lLog[idx]} !==
                    {4'hF, BW'(((k % NS) << 16) | ((k / NS) << 8) | b), b == 2}) begin
                    nFail++;
                    $display("FAIL rr_beat pkt%0d b%0d got=%b/%h/%b want=1111/%h/%b",
                             k, b, vLog[idx], dLog[idx], lLog[idx],
                             BW'(((k % NS) << 16) | ((k / NS) << 8) | b), b == 2);
                end
                idx++;
            end
            if (k == 3) begin
                nTests++;
                if (cLog[idx-1] !== CW'(4)) begin
                    nFail++;
                    $display("FAIL rr_count got=%0d want=4", cLog[idx-1]);
                end
            end
            nTests++;
            if (vLog[idx] !== '0) begin
                nFail++;
                $display("FAIL rr_gap pkt%0d got=%b want=0000", k, vLog[idx]);
            end
            idx++;
        end
    endtask

    task automatic test_backpressure();
        logic [BW-1:0] got [$];
        logic [BW-1:0] prevData;
        logic          held;
        applyReset();
        held = 1'b0;
        prevData = '0;
        for (int b = 0; b < 4; b++)
            srcQ[2].push_back(mk({4{8'hA0 + 8'(b)}}, 4'hF, b == 3));
        for (int c = 0; c < 40 && got.size() < 4; c++) begin
            sinkRdy = (c % 2 == 0);
            drive();
            if (held) begin
                nTests++;
                if (dataOut !== prevData) begin
                    nFail++;
                    $display("FAIL bp_hold got=%h want=%h", dataOut, prevData);
                end
            end
            held = 1'b0;
            if (validOut != '0 && !readyIn) begin
                nTests++;
                if (srcReady[2] !== 1'b0) begin
                    nFail++;
                    $display("FAIL bp_ready got=%b want=0", srcReady[2]);
                end
                held = 1'b1;
                prevData = dataOut;
            end
            if (validOut != '0 && readyIn) got.push_back(dataOut);
            advance();
        end
        nTests++;
        if (got.size() != 4) begin
            nFail++;
            $display("FAIL bp_beats got=%0d want=4", got.size());
        end
        for (int b = 0; b < 4 && b < got.size(); b++) begin
            nTests++;
            if (got[b] !== {4{8'hA0 + 8'(b)}}) begin
                nFail++;
                $display("FAIL bp_order b%0d got=%h want=%h", b, got[b], {4{8'hA0 + 8'(b)}});
            end
        end
        sinkRdy = 1'b1;
        drive();
        nTests++;
        if (validOut !== '0) begin
            nFail++;
            $display("FAIL bp_no_repeat got=%b want=0000", validOut);
        end
        advance();
    endtask

    task automatic test_stall();
        int  pc;
        int  lastAt;
        bit  src0Q;
        bit  done;
        applyReset();
        pc = 0;
        lastAt = -1;
        src0Q = 1'b0;
        done = 1'b0;
        for (int b = 0; b < 4; b++) srcQ[1].push_back(mk(32'h100 + b, 4'hF, b == 3));
        for (int c = 0; c < 50 && !done; c++) begin
            pause[1] = (srcQ[1].size() == 2 && pc < 5);
            drive();
            if (pause[1]) begin
                pc++;
                nTests++;
                if (grantOut !== 4'b0010 || srcReady[0] !== 1'b0) begin
                    nFail++;
                    $display("FAIL stall_hold grant=%b ready0=%b want 0010/0", grantOut, srcReady[0]);
                end
            end
            if (grantOut == 4'b0010 && !src0Q) begin
                srcQ[0].push_back(mk(32'h55, 4'hF, 1'b0));
                srcQ[0].push_back(mk(32'h56, 4'hF, 1'b1));
                src0Q = 1'b1;
            end
            if (lastAt >= 0 && c == lastAt + 1) begin
                nTests++;
                if (grantOut !== '0) begin
                    nFail++;
                    $display("FAIL stall_idle got=%b want=0000", grantOut);
                end
            end
            if (lastAt >= 0 && c == lastAt + 2) begin
                nTests++;
                if (grantOut !== 4'b0001) begin
                    nFail++;
                    $display("FAIL stall_next got=%b want=0001", grantOut);
                end
                done = 1'b1;
            end
            if (srcReady[1] && srcValid[1] != '0 && srcLast[1]) lastAt = c;
            advance();
        end
        pause = '0;
        nTests++;
        if (!done || pc != 5) begin
            nFail++;
            $display("FAIL stall_timeout done=%0d paused=%0d want 1/5", done, pc);
        end
    endtask

    task automatic test_lanes();
        bit seen;
        applyReset();
        seen = 1'b0;
        srcQ[3].push_back(mk(32'h44332211, 4'b0101, 1'b1));
        for (int c = 0; c < 10 && !seen; c++) begin
            drive();
            if (validOut != '0) begin
                seen = 1'b1;
                nTests++;
                if ({validOut, dataOut, lastOut} !== {4'b0101, 32'h44332211, 1'b1} || c != 2) begin
                    nFail++;
                    $display("FAIL lanes got=%b/%h/%b cyc%0d want=0101/44332211/1 cyc2",
                             validOut, dataOut, lastOut, c);
                end
            end
            advance();
        end
        nTests++;
        if (!seen) begin
            nFail++;
            $display("FAIL lanes_timeout got=none want=beat");
        end
    endtask

    task automatic test_wrap();
        int beats;
        applyReset();
        beats = 0;
        for (int k = 0; k < 17; k++) srcQ[k % NS].push_back(mk(BW'(k), 4'hF, 1'b1));
        for (int c = 0; c < 100 && beats < 17; c++) begin
            drive();
            if (validOut != '0) begin
                beats++;
                nTests++;
                if (lastOut !== 1'b1 || pktCountOut !== CW'(beats)) begin
                    nFail++;
                    $display("FAIL wrap beat%0d last=%b count=%0d want 1/%0d",
                             beats, lastOut, pktCountOut, CW'(beats));
                end
            end
            advance();
        end
        nTests++;
        if (beats != 17 || pktCountOut !== CW'(1)) begin
            nFail++;
            $display("FAIL wrap_end beats=%0d count=%0d want 17/1", beats, pktCountOut);
        end
    endtask

    task automatic test_random();
        int owner;
        int ptr;
        int cnt;
        int pktId;
        beat_t expQ [$];
        logic [NS-1:0] req;
        logic [NS-1:0] expG;
        logic [NS-1:0] expR;
        bit take;
        bit acc;
        beat_t nb;
        applyReset();
        owner = -1;
        ptr = 0;
        cnt = 0;
        pktId = 0;
        for (int c = 0; c < 900; c++) begin
            for (int s = 0; s < NS; s++) begin
                if (srcQ[s].size() == 0 && $urandom_range(0, 3) == 0) begin
                    int len;
                    len = $urandom_range(1, 4);
                    for (int b = 0; b < len; b++)
                        srcQ[s].push_back(mk({8'(s), 8'(pktId), 8'(b), 8'($urandom)},
                                             VS'($urandom_range(1, 15)), b == len - 1));
                    pktId++;
                end
                pause[s] = ($urandom_range(0, 4) == 0);
            end
            sinkRdy = ($urandom_range(0, 9) < 7);
            drive();
            for (int s = 0; s < NS; s++) req[s] = srcQ[s].size() > 0 && !pause[s];
            expG = (owner < 0) ? '0 : NS'(1) << owner;
            expR = (owner >= 0 && (expQ.size() == 0 || sinkRdy)) ? expG : '0;
            nTests++;
            if (grantOut !== expG) begin
                nFail++;
                $display("FAIL rnd_grant cyc%0d got=%b want=%b", c, grantOut, expG);
            end
            nTests++;
            if (readyOut !== expR) begin
                nFail++;
                $display("FAIL rnd_ready cyc%0d got=%b want=%b", c, readyOut, expR);
            end
            nTests++;
            if (expQ.size() == 0) begin
                if ({validOut, lastOut} !== '0) begin
                    nFail++;
                    $display("FAIL rnd_empty cyc%0d got=%b/%b want=0/0", c, validOut, lastOut);
                end
            end else if ({validOut, dataOut, lastOut} !== {expQ[0].v, expQ[0].d, expQ[0].l}) begin
                nFail++;
                $display("FAIL rnd_beat cyc%0d got=%b/%h/%b want=%b/%h/%b", c,
                         validOut, dataOut, lastOut, expQ[0].v, expQ[0].d, expQ[0].l);
            end
            nTests++;
            if (pktCountOut !== CW'(cnt)) begin
                nFail++;
                $display("FAIL rnd_count cyc%0d got=%0d want=%0d", c, pktCountOut, CW'(cnt));
            end
            take = expQ.size() > 0 && sinkRdy;
            acc  = owner >= 0 && req[owner] && (expQ.size() == 0 || sinkRdy);
            if (take) void'(expQ.pop_front());
            if (owner < 0) begin
                for (int i = 0; i < NS; i++) begin
                    if (owner < 0 && req[(ptr + i) % NS]) owner = (ptr + i) % NS;
                end
            end else if (acc) begin
                nb = srcQ[owner][0];
                expQ.push_back(nb);
                if (nb.l) begin
                    cnt++;
                    ptr = (owner + 1) % NS;
                    owner = -1;
                end
            end
            advance();
        end
        pause = '0;
    endtask

    initial begin
        pause   = '0;
        sinkRdy = 1'b1;
        readyIn = 1'b1;
        test_reset();
        test_round_robin();
        test_backpressure();
        test_stall();
        test_lanes();
        test_wrap();
        test_random();
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
